// File: rtl/sim_run_ctrl.sv
// End-of-simulation controller: halt/timeout/error termination with an error drain window.
// Optional macro RUN_CTRL_PROGRESS_WDOG_EN turns the watchdog into a commit-driven deadlock detector.
module sim_run_ctrl #(
  parameter int unsigned NUM_HALT       = 8,
  parameter int unsigned NUM_ERR        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 10000000,
  parameter int unsigned TO_W           = 32,
  parameter int unsigned ERR_DRAIN      = 5,
  parameter int unsigned CYC_W          = 40,
  localparam int unsigned HIdxW         = (NUM_HALT > 1) ? $clog2(NUM_HALT) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_HALT-1:0] halt_i,
  input  logic [NUM_ERR-1:0]  err_i,
  input  logic                commit_i,
  output logic                done_o,
  output logic                finish_pulse_o,
  output logic [1:0]          cause_o,
  output logic [HIdxW-1:0]    halt_idx_o,
  output logic [NUM_ERR-1:0]  err_vec_o,
  output logic [CYC_W-1:0]    cycles_o
);

  localparam int unsigned     DrW       = (ERR_DRAIN > 1) ? $clog2(ERR_DRAIN) : 1;
  localparam logic [TO_W-1:0] ToReload  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [DrW-1:0]  DrReload  = DrW'(ERR_DRAIN - 1);
  localparam bit              TimeoutEn = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;
  typedef enum logic [1:0] {
    CauseNone    = 2'd0,
    CauseHalt    = 2'd1,
    CauseTimeout = 2'd2,
    CauseError   = 2'd3
  } cause_e;

  state_e             state_q, state_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [DrW-1:0]     drain_q, drain_d;
  cause_e             cause_q, cause_d;
  logic [HIdxW-1:0]   halt_idx_q, halt_idx_d;
  logic [NUM_ERR-1:0] err_vec_q, err_vec_d;
  logic [CYC_W-1:0]   cycles_q, cycles_d;
  logic               done_q, done_d;
  logic               pulse_q, pulse_d;

  logic               progress;
  logic               to_expired;
  logic [HIdxW-1:0]   low_idx;

`ifdef RUN_CTRL_PROGRESS_WDOG_EN
  assign progress = commit_i;
`else
  logic unused_commit;
  assign unused_commit = commit_i;
  assign progress      = 1'b0;
`endif

  // A commit in the expiry cycle counts as progress, so expiry needs T+1 idle cycles in a row.
  assign to_expired = TimeoutEn && (to_cnt_q == '0) && !progress;

  always_comb begin
    low_idx = '0;
    for (int i = NUM_HALT - 1; i >= 0; i--) begin
      if (halt_i[i]) low_idx = HIdxW'(i);
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StRun;
      to_cnt_q   <= ToReload;
      drain_q    <= '0;
      cause_q    <= CauseNone;
      halt_idx_q <= '0;
      err_vec_q  <= '0;
      cycles_q   <= '0;
      done_q     <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      drain_q    <= drain_d;
      cause_q    <= cause_d;
      halt_idx_q <= halt_idx_d;
      err_vec_q  <= err_vec_d;
      cycles_q   <= cycles_d;
      done_q     <= done_d;
      pulse_q    <= pulse_d;
    end
  end

  // Next-state logic; event priority in RUN is halt > timeout > error
  always_comb begin
    state_d    = state_q;
    to_cnt_d   = to_cnt_q;
    drain_d    = drain_q;
    cause_d    = cause_q;
    halt_idx_d = halt_idx_q;
    err_vec_d  = err_vec_q;
    unique case (state_q)
      StRun: begin
        if (|halt_i) begin
          state_d    = StDone;
          cause_d    = CauseHalt;
          halt_idx_d = low_idx;
        end else if (to_expired) begin
          state_d = StDone;
          cause_d = CauseTimeout;
        end else if (|err_i) begin
          state_d   = StDrain;
          drain_d   = DrReload;
          err_vec_d = err_vec_q | err_i;
        end else if (progress) begin
          to_cnt_d = ToReload;
        end else if (to_cnt_q != '0) begin
          to_cnt_d = to_cnt_q - 1'b1;
        end
      end
      StDrain: begin
        err_vec_d = err_vec_q | err_i;
        if (drain_q == '0) begin
          state_d = StDone;
          cause_d = CauseError;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output logic (registered from next state)
  always_comb begin
    cycles_d = cycles_q;
    if (state_q != StDone && cycles_q != '1) cycles_d = cycles_q + 1'b1;
    done_d  = (state_d == StDone);
    pulse_d = (state_d == StDone) && (state_q != StDone);
  end

  assign done_o         = done_q;
  assign finish_pulse_o = pulse_q;
  assign cause_o        = cause_q;
  assign halt_idx_o     = halt_idx_q;
  assign err_vec_o      = err_vec_q;
  assign cycles_o       = cycles_q;

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i && state_q == StRun) begin
      assert (!$isunknown(halt_i));
      assert (!$isunknown(err_i));
    end
  end
`endif

endmodule
